// File: rtl/secuenciador_multiciclo.sv
// Multi-cycle control sequencer for the RV32I core.
// Walks each instruction through fetch, decode, execute, memory and write-back.
// Drives the ALU mode, the datapath muxes and the unified memory handshake.
module secuenciador_multiciclo #(
  parameter int unsigned TIMEOUT_MEM = 0,
  parameter bit          FENCE_NOP   = 1'b1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [6:0] op,
  input  logic       cond,
  input  logic       mem_listo,
  output logic [1:0] modo,
  output logic [1:0] sel_op1,
  output logic [1:0] sel_op2,
  output logic [1:0] sel_dato,
  output logic       sel_dir,
  output logic       sel_pc,
  output logic       lee_mem,
  output logic       escribe_mem,
  output logic       escribe_ir,
  output logic       guarda_pc4,
  output logic       escribe_pc,
  output logic       escribe_reg,
  output logic [2:0] estado,
  output logic [1:0] error
);

  typedef enum logic [2:0] {
    BUSQUEDA   = 3'd0,
    DECODIFICA = 3'd1,
    EJECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRIBE    = 3'd4,
    SALTO      = 3'd5,
    ERROR      = 3'd7
  } estado_t;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_FENCE  = 7'd15;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_OP     = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  estado_t     estado_q, estado_d;
  logic        cond_q, cond_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  error_q, error_d;
  logic        legal;
  logic        expira;

  // Opcode legality check used at decode.
  always_comb begin
    unique case (op)
      OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: legal = 1'b1;
      OP_FENCE:                            legal = FENCE_NOP;
      default:                             legal = 1'b0;
    endcase
  end

  // Wait-cycle limit reached this cycle; a simultaneous mem_listo still wins.
  assign expira = (TIMEOUT_MEM != 0) && ((cnt_q + 32'd1) >= TIMEOUT_MEM);

  // Next-state, branch-condition latch, wait counter and sticky error.
  always_comb begin
    estado_d = estado_q;
    cond_d   = cond_q;
    cnt_d    = cnt_q;
    error_d  = error_q;
    case (estado_q)
      BUSQUEDA, MEMORIA: begin
        if (mem_listo) begin
          if (estado_q == BUSQUEDA) begin
            estado_d = DECODIFICA;
          end else if (op == OP_LOAD) begin
            estado_d = ESCRIBE;
          end else begin
            estado_d = BUSQUEDA;
            cnt_d    = '0;
          end
        end else if (expira) begin
          estado_d = ERROR;
          error_d  = 2'b10;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DECODIFICA: begin
        if (legal) begin
          estado_d = EJECUTA;
        end else begin
          estado_d = ERROR;
          error_d  = 2'b01;
        end
      end
      EJECUTA: begin
        case (op)
          OP_OP, OP_IMM, OP_LUI, OP_AUIPC: estado_d = ESCRIBE;
          OP_LOAD, OP_STORE: begin
            estado_d = MEMORIA;
            cnt_d    = '0;
          end
          OP_BRANCH: begin
            estado_d = SALTO;
            cond_d   = cond;
          end
          OP_JAL, OP_JALR, OP_FENCE: begin
            estado_d = BUSQUEDA;
            cnt_d    = '0;
          end
          default: begin
            estado_d = ERROR;
            error_d  = 2'b01;
          end
        endcase
      end
      ESCRIBE, SALTO: begin
        estado_d = BUSQUEDA;
        cnt_d    = '0;
      end
      default: estado_d = ERROR;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      estado_q <= BUSQUEDA;
      cond_q   <= 1'b0;
      cnt_q    <= '0;
      error_q  <= 2'b00;
    end else begin
      estado_q <= estado_d;
      cond_q   <= cond_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
    end
  end

  // Output decode; everything held low while reset is asserted.
  always_comb begin
    modo        = 2'b00;
    sel_op1     = 2'b00;
    sel_op2     = 2'b00;
    sel_dato    = 2'b00;
    sel_dir     = 1'b0;
    sel_pc      = 1'b0;
    lee_mem     = 1'b0;
    escribe_mem = 1'b0;
    escribe_ir  = 1'b0;
    guarda_pc4  = 1'b0;
    escribe_pc  = 1'b0;
    escribe_reg = 1'b0;
    if (nreset) begin
      case (estado_q)
        BUSQUEDA: begin
          lee_mem    = 1'b1;
          escribe_ir = mem_listo;
        end
        DECODIFICA: begin
          sel_op1    = 2'b01;
          sel_op2    = 2'b10;
          guarda_pc4 = 1'b1;
        end
        EJECUTA: begin
          case (op)
            OP_OP:  modo = 2'b10;
            OP_IMM: begin
              sel_op2 = 2'b01;
              modo    = 2'b01;
            end
            OP_LUI: begin
              sel_op1 = 2'b10;
              sel_op2 = 2'b01;
            end
            OP_AUIPC: begin
              sel_op1 = 2'b01;
              sel_op2 = 2'b01;
            end
            OP_LOAD, OP_STORE: sel_op2 = 2'b01;
            OP_BRANCH: modo = 2'b11;
            OP_JAL, OP_JALR: begin
              sel_op1     = (op == OP_JAL) ? 2'b01 : 2'b00;
              sel_op2     = 2'b01;
              escribe_pc  = 1'b1;
              sel_pc      = 1'b1;
              escribe_reg = 1'b1;
              sel_dato    = 2'b10;
            end
            OP_FENCE: escribe_pc = 1'b1;
            default: ;
          endcase
        end
        MEMORIA: begin
          sel_dir     = 1'b1;
          lee_mem     = (op == OP_LOAD);
          escribe_mem = (op == OP_STORE);
          escribe_pc  = (op == OP_STORE) && mem_listo;
        end
        ESCRIBE: begin
          escribe_reg = 1'b1;
          sel_dato    = (op == OP_LOAD) ? 2'b01 : 2'b00;
          escribe_pc  = 1'b1;
        end
        SALTO: begin
          sel_op1    = 2'b01;
          sel_op2    = 2'b01;
          escribe_pc = 1'b1;
          sel_pc     = cond_q;
        end
        default: ;
      endcase
    end
  end

  assign estado = estado_q;
  assign error  = error_q;

endmodule

// File: tb/tb_secuenciador_multiciclo.sv
// Scoreboard bench for secuenciador_multiciclo: stimulus pushes the expected
// output vector of each cycle, a negedge monitor pops and compares.
module tb_secuenciador_multiciclo;

  logic       clk;
  logic       nreset;
  logic [6:0] op;
  logic       cond;
  logic       mem_listo;
  logic [1:0] modo, sel_op1, sel_op2, sel_dato, error;
  logic       sel_dir, sel_pc, lee_mem, escribe_mem, escribe_ir;
  logic       guarda_pc4, escribe_pc, escribe_reg;
  logic [2:0] estado;

  secuenciador_multiciclo #(.TIMEOUT_MEM(4), .FENCE_NOP(1'b1)) dut (
    .clk(clk), .nreset(nreset), .op(op), .cond(cond), .mem_listo(mem_listo),
    .modo(modo), .sel_op1(sel_op1), .sel_op2(sel_op2), .sel_dato(sel_dato),
    .sel_dir(sel_dir), .sel_pc(sel_pc), .lee_mem(lee_mem),
    .escribe_mem(escribe_mem), .escribe_ir(escribe_ir), .guarda_pc4(guarda_pc4),
    .escribe_pc(escribe_pc), .escribe_reg(escribe_reg), .estado(estado),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] est;
    logic [1:0] modo, op1, op2, dato;
    logic       dir, pc, lee, wm, ir, pc4, wpc, wreg;
    logic [1:0] err;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } item_t;

  item_t sbq[$];
  int unsigned checks = 0;
  int unsigned passed = 0;

  function automatic exp_t ex(input logic [2:0] est, input logic [1:0] md,
                              input logic [1:0] o1, input logic [1:0] o2,
                              input logic [1:0] dt, input logic dir,
                              input logic pc, input logic lee, input logic wm,
                              input logic ir, input logic pc4, input logic wpc,
                              input logic wreg, input logic [1:0] err);
    exp_t r;
    r.est = est; r.modo = md; r.op1 = o1; r.op2 = o2; r.dato = dt;
    r.dir = dir; r.pc = pc; r.lee = lee; r.wm = wm; r.ir = ir;
    r.pc4 = pc4; r.wpc = wpc; r.wreg = wreg; r.err = err;
    return r;
  endfunction

  // Monitor: compare the DUT outputs against the next queued expectation.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      item_t it;
      exp_t  got;
      it = sbq.pop_front();
      got = ex(estado, modo, sel_op1, sel_op2, sel_dato, sel_dir, sel_pc,
               lee_mem, escribe_mem, escribe_ir, guarda_pc4, escribe_pc,
               escribe_reg, error);
      checks++;
      if (got === it.e) passed++;
      else $display("FAIL %s: got %b required %b (est|modo|op1|op2|dato|dir|pc|lee|wm|ir|pc4|wpc|wreg|err)",
                    it.name, got, it.e);
    end
  end

  task automatic step(input string name, input logic rst, input logic [6:0] o,
                      input logic lst, input logic c, input exp_t e);
    item_t it;
    @(posedge clk);
    #1;
    nreset = rst; op = o; mem_listo = lst; cond = c;
    it.name = name; it.e = e;
    sbq.push_back(it);
  endtask

  exp_t Z, FW, FD, DEC, EX_OP, EX_IMM, EX_LUI, EX_AUIPC, EX_MEM, EX_BR;
  exp_t EX_JAL, EX_JALR, EX_FENCE, MEM_LD, MEM_ST_W, MEM_ST_D;
  exp_t WB_ALU, WB_LD, SAL_T, SAL_N, ERR01, ERR10;

  initial begin
    nreset = 1'b0; op = 7'd51; mem_listo = 1'b1; cond = 1'b0;
    //            est modo op1 op2 dato dir pc lee wm ir pc4 wpc wreg err
    Z        = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    FW       = ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    FD       = ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    DEC      = ex(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    EX_OP    = ex(2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    EX_IMM   = ex(2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    EX_LUI   = ex(2, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    EX_AUIPC = ex(2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    EX_MEM   = ex(2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    EX_BR    = ex(2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    EX_JAL   = ex(2, 0, 1, 1, 2, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    EX_JALR  = ex(2, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    EX_FENCE = ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    MEM_LD   = ex(3, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    MEM_ST_W = ex(3, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    MEM_ST_D = ex(3, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    WB_ALU   = ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    WB_LD    = ex(4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    SAL_T    = ex(5, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    SAL_N    = ex(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    ERR01    = ex(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    ERR10    = ex(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

    step("reset0", 0, 7'd51, 1, 0, Z);
    step("reset1", 0, 7'd51, 1, 0, Z);
    // OP: 0,1,2,4
    step("op_fetch", 1, 7'd51, 1, 0, FD);
    step("op_dec",   1, 7'd51, 1, 0, DEC);
    step("op_exe",   1, 7'd51, 1, 0, EX_OP);
    step("op_wb",    1, 7'd51, 1, 0, WB_ALU);
    // OP-IMM, LUI, AUIPC
    step("imm_fetch", 1, 7'd19, 1, 0, FD);
    step("imm_dec",   1, 7'd19, 0, 0, DEC);
    step("imm_exe",   1, 7'd19, 1, 0, EX_IMM);
    step("imm_wb",    1, 7'd19, 1, 0, WB_ALU);
    step("lui_fetch", 1, 7'd55, 1, 0, FD);
    step("lui_dec",   1, 7'd55, 1, 0, DEC);
    step("lui_exe",   1, 7'd55, 1, 0, EX_LUI);
    step("lui_wb",    1, 7'd55, 1, 0, WB_ALU);
    step("aui_fetch", 1, 7'd23, 1, 0, FD);
    step("aui_dec",   1, 7'd23, 1, 0, DEC);
    step("aui_exe",   1, 7'd23, 1, 0, EX_AUIPC);
    step("aui_wb",    1, 7'd23, 1, 0, WB_ALU);
    // Load with 3 wait cycles in MEMORIA
    step("ld_fetch", 1, 7'd3, 1, 0, FD);
    step("ld_dec",   1, 7'd3, 1, 0, DEC);
    step("ld_exe",   1, 7'd3, 1, 0, EX_MEM);
    step("ld_mem_w1", 1, 7'd3, 0, 0, MEM_LD);
    step("ld_mem_w2", 1, 7'd3, 0, 0, MEM_LD);
    step("ld_mem_w3", 1, 7'd3, 0, 0, MEM_LD);
    step("ld_mem_ok", 1, 7'd3, 1, 0, MEM_LD);
    step("ld_wb",    1, 7'd3, 1, 0, WB_LD);
    // Store, zero wait
    step("st_fetch", 1, 7'd35, 1, 0, FD);
    step("st_dec",   1, 7'd35, 1, 0, DEC);
    step("st_exe",   1, 7'd35, 1, 0, EX_MEM);
    step("st_mem",   1, 7'd35, 1, 0, MEM_ST_D);
    // Branch taken (cond flips after EJECUTA to show it was latched)
    step("bt_fetch", 1, 7'd99, 1, 0, FD);
    step("bt_dec",   1, 7'd99, 1, 0, DEC);
    step("bt_exe",   1, 7'd99, 1, 1, EX_BR);
    step("bt_salto", 1, 7'd99, 1, 0, SAL_T);
    step("bn_fetch", 1, 7'd99, 1, 1, FD);
    step("bn_dec",   1, 7'd99, 1, 1, DEC);
    step("bn_exe",   1, 7'd99, 1, 0, EX_BR);
    step("bn_salto", 1, 7'd99, 1, 1, SAL_N);
    // JAL, JALR, FENCE
    step("jal_fetch", 1, 7'd111, 1, 0, FD);
    step("jal_dec",   1, 7'd111, 1, 0, DEC);
    step("jal_exe",   1, 7'd111, 1, 0, EX_JAL);
    step("jalr_fetch", 1, 7'd103, 1, 0, FD);
    step("jalr_dec",   1, 7'd103, 1, 0, DEC);
    step("jalr_exe",   1, 7'd103, 1, 0, EX_JALR);
    step("fen_fetch", 1, 7'd15, 1, 0, FD);
    step("fen_dec",   1, 7'd15, 1, 0, DEC);
    step("fen_exe",   1, 7'd15, 1, 0, EX_FENCE);
    // Fetch completing exactly as the wait limit is hit
    step("lim_w1", 1, 7'd51, 0, 0, FW);
    step("lim_w2", 1, 7'd51, 0, 0, FW);
    step("lim_w3", 1, 7'd51, 0, 0, FW);
    step("lim_ok", 1, 7'd51, 1, 0, FD);
    step("lim_dec", 1, 7'd51, 1, 0, DEC);
    step("lim_exe", 1, 7'd51, 1, 0, EX_OP);
    step("lim_wb",  1, 7'd51, 1, 0, WB_ALU);
    // Reset in the middle of a store access
    step("rs_fetch", 1, 7'd35, 1, 0, FD);
    step("rs_dec",   1, 7'd35, 1, 0, DEC);
    step("rs_exe",   1, 7'd35, 1, 0, EX_MEM);
    step("rs_mem_w", 1, 7'd35, 0, 0, MEM_ST_W);
    step("rs_reset", 0, 7'd35, 0, 0, Z);
    step("rs_fw",    1, 7'd35, 0, 0, FW);
    // Timeout in BUSQUEDA (continues waiting from the previous cycle)
    step("to_w2", 1, 7'd51, 0, 0, FW);
    step("to_w3", 1, 7'd51, 0, 0, FW);
    step("to_w4", 1, 7'd51, 0, 0, FW);
    step("to_err", 1, 7'd51, 0, 0, ERR10);
    step("to_err_listo", 1, 7'd51, 1, 0, ERR10);
    step("to_reset", 0, 7'd51, 1, 0, Z);
    // Illegal opcode
    step("il_fetch", 1, 7'd115, 1, 0, FD);
    step("il_dec",   1, 7'd115, 1, 0, DEC);
    for (int i = 0; i < 10; i++) step("il_err", 1, 7'd115, 1, 0, ERR01);
    step("il_reset", 0, 7'd115, 1, 0, Z);
    step("il_fw",    1, 7'd51, 0, 0, FW);
    step("il_fd",    1, 7'd51, 1, 0, FD);

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending required 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/secuenciador_multiciclo.md
Name: secuenciador_multiciclo

Overview:
- Main multi-cycle control FSM of the RV32I core.
- Sequences fetch, decode, execute, memory and write-back for each instruction, driving `modo` into `control_alu` (00 add, 01 OP-IMM, 10 OP, 11 branch compare), the datapath operand/result muxes and the memory read/write handshake.
- Sits between the instruction register, the shared ALU and the unified memory port. One instruction is in flight at a time.

Parameters:
- TIMEOUT_MEM, 0, max cycles waiting for `mem_listo` per access; 0 disables the timeout.
- FENCE_NOP, 1, 1: opcode 15 (FENCE) executes as a NOP; 0: opcode 15 is illegal.

Ports:
- clk  in  1  system clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- op  in  7  opcode from instruction register; stable except while `escribe_ir` is asserted.
- cond  in  1  ALU compare result (1 = branch taken), valid while `modo`=11.
- mem_listo  in  1  memory ready; completes the current access in the cycle it is 1.
- modo  out  2  mode for `control_alu`.
- sel_op1  out  2  ALU operand 1 select: 00 rs1, 01 pc, 10 zero.
- sel_op2  out  2  ALU operand 2 select: 00 rs2, 01 imm, 10 constant 4.
- sel_dato  out  2  register write-back source: 00 ALU result reg, 01 memory data reg, 10 pc+4 reg.
- sel_dir  out  1  memory address select: 0 pc, 1 ALU result reg.
- sel_pc  out  1  next-pc select: 0 pc+4 reg, 1 ALU output.
- lee_mem  out  1  memory read request.
- escribe_mem  out  1  memory write request.
- escribe_ir  out  1  load instruction register.
- guarda_pc4  out  1  latch ALU output into pc+4 reg.
- escribe_pc  out  1  pc write enable.
- escribe_reg  out  1  register file write enable.
- estado  out  3  current state encoding (debug).
- error  out  2  sticky: 00 none, 01 illegal opcode, 10 memory timeout.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `nreset` is asynchronous, active-low.
- State encoding: BUSQUEDA=0, DECODIFICA=1, EJECUTA=2, MEMORIA=3, ESCRIBE=4, SALTO=5, ERROR=7.
- Outputs: decoded combinationally from state, `op`, `mem_listo` and `cond_reg`. Unlisted outputs are 0 and `modo`=00.
- Reset (`nreset`=0, any time, including mid-access):
  - State → BUSQUEDA, `cond_reg`=0, timeout counter=0, `error`=00.
  - All enables and requests are forced 0 while `nreset`=0; `estado`=0.
  - The first fetch request appears in the first cycle after release.
- BUSQUEDA: `lee_mem`=1, `sel_dir`=0. Hold until `mem_listo`=1; in that cycle `escribe_ir`=1, then go to DECODIFICA.
- DECODIFICA: `sel_op1`=01, `sel_op2`=10, `modo`=00, `guarda_pc4`=1. Then:
  - Legal opcode → EJECUTA.
  - Illegal opcode → ERROR with `error`=01.
  - Legal opcodes: 55, 23, 111, 103, 99, 3, 35, 19, 51, and 15 if FENCE_NOP=1.
- EJECUTA, by opcode:
  - 51: op1 00, op2 00, `modo` 10 → ESCRIBE.
  - 19: 00, 01, `modo` 01 → ESCRIBE.
  - 55 (LUI): 10, 01, 00 → ESCRIBE.
  - 23 (AUIPC): 01, 01, 00 → ESCRIBE.
  - 3 and 35: 00, 01, 00 → MEMORIA.
  - 99: 00, 00, `modo` 11; register `cond` into `cond_reg` → SALTO.
  - 111: 01, 01, 00; `escribe_pc`=1, `sel_pc`=1, `escribe_reg`=1, `sel_dato`=10 → BUSQUEDA.
  - 103: same as 111 but op1=00.
  - 15: `escribe_pc`=1, `sel_pc`=0 → BUSQUEDA.
- MEMORIA: `sel_dir`=1; `lee_mem`=1 for opcode 3, `escribe_mem`=1 for opcode 35. Hold until `mem_listo`=1, then:
  - Load → ESCRIBE.
  - Store: in that same cycle `escribe_pc`=1, `sel_pc`=0 → BUSQUEDA.
- ESCRIBE: `escribe_reg`=1, `sel_dato`=01 for loads else 00; `escribe_pc`=1, `sel_pc`=0 → BUSQUEDA.
- SALTO: `sel_op1`=01, `sel_op2`=01, `modo`=00, `escribe_pc`=1, `sel_pc`=`cond_reg` → BUSQUEDA.
- Memory requests: `lee_mem`/`escribe_mem` never drop before `mem_listo` is seen, and never both 1. A `mem_listo` outside BUSQUEDA/MEMORIA is ignored.
- Timeout:
  - The counter clears on entry to BUSQUEDA/MEMORIA and increments each cycle waiting with `mem_listo`=0.
  - If TIMEOUT_MEM>0 and the counter reaches TIMEOUT_MEM → ERROR with `error`=10, requests dropped.
  - `mem_listo`=1 in the same cycle the limit is hit wins (access completes).
- ERROR: all enables 0, `estado`=7, `error` held. Leaves only via reset.
- Latency (zero-wait memory, `mem_listo` tied 1):
  - OP/OP-IMM/LUI/AUIPC/load: 4 cycles (load adds MEMORIA: 5).
  - Store: 4.
  - Branch: 4.
  - JAL/JALR/FENCE: 3.

Test Plan:
- Reset, `mem_listo`=1, `op`=51 → `estado` sequence 0,1,2,4,0. `modo`=10 in EJECUTA; `escribe_reg`=1, `escribe_pc`=1, `sel_pc`=0 in ESCRIBE. 4 cycles per instruction.
- `op`=3, `mem_listo` low 3 cycles in MEMORIA → `lee_mem`=1, `sel_dir`=1 held 4 cycles; then ESCRIBE with `sel_dato`=01, `escribe_reg`=1.
- `op`=99 with `cond`=1, then `cond`=0 → EJECUTA `modo`=11; SALTO `sel_pc`=1 then `sel_pc`=0; `escribe_pc`=1 both times; no `escribe_reg`.
- `op`=111 → EJECUTA asserts `escribe_pc`=1, `sel_pc`=1, `escribe_reg`=1, `sel_dato`=10; next state 0.
- `op`=115 → `estado`=7, `error`=01, all enables 0 for 10 cycles; `nreset` pulse → `estado`=0, `error`=00, `lee_mem`=1 after release.
- TIMEOUT_MEM=4, `mem_listo`=0 in BUSQUEDA → `estado`=7 and `error`=10 after 4 waiting cycles. Separately, `nreset` asserted mid-MEMORIA store → `escribe_mem` drops immediately, `estado`=0.
